// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and main-memory signals shared by mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_LEN = 32,
  parameter int LINE_W   = 128
);
  logic                ic_req_valid;
  logic [ADDR_LEN-1:0] ic_req_addr;
  logic                ic_grant;
  logic                ic_resp_valid;
  logic [LINE_W-1:0]   ic_resp_data;

  logic                dc_req_valid;
  logic                dc_req_rw;
  logic [ADDR_LEN-1:0] dc_req_addr;
  logic [LINE_W-1:0]   dc_req_data;
  logic                dc_grant;
  logic                dc_resp_valid;
  logic [LINE_W-1:0]   dc_resp_data;

  logic                mem_req_valid;
  logic                mem_req_rw;
  logic [ADDR_LEN-1:0] mem_req_addr;
  logic [LINE_W-1:0]   mem_req_data;
  logic                mem_resp_valid;
  logic [LINE_W-1:0]   mem_resp_data;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
    input  mem_resp_valid, mem_resp_data,
    output ic_grant, ic_resp_valid, ic_resp_data,
    output dc_grant, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
    output mem_resp_valid, mem_resp_data,
    input  ic_grant, ic_resp_valid, ic_resp_data,
    input  dc_grant, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between icache and dcache,
// one transaction at a time, with responses steered back to the current owner.
module mem_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int LINE_W   = 128
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic       SRV_I  = 1'b0;
  localparam logic       SRV_D  = 1'b1;

  logic [1:0]          r_state;
  logic                r_lastSrv;
  logic                r_icGrant;
  logic                r_dcGrant;
  logic                r_memReqValid;
  logic                r_memReqRw;
  logic [ADDR_LEN-1:0] r_memReqAddr;
  logic [LINE_W-1:0]   r_memReqData;

  logic w_pickD;
  logic w_pickI;
  logic w_icResp;
  logic w_dcResp;

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign w_pickD  = bus.dc_req_valid && (!bus.ic_req_valid || (r_lastSrv == SRV_I));
  assign w_pickI  = bus.ic_req_valid && !w_pickD;
  assign w_icResp = (r_state == BUSY_I) && bus.mem_resp_valid;
  assign w_dcResp = (r_state == BUSY_D) && bus.mem_resp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_lastSrv     <= SRV_I;
      r_icGrant     <= 1'b0;
      r_dcGrant     <= 1'b0;
      r_memReqValid <= 1'b0;
      r_memReqRw    <= 1'b0;
      r_memReqAddr  <= '0;
      r_memReqData  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickD) begin
            r_state       <= BUSY_D;
            r_dcGrant     <= 1'b1;
            r_memReqValid <= 1'b1;
            r_memReqRw    <= bus.dc_req_rw;
            r_memReqAddr  <= bus.dc_req_addr;
            r_memReqData  <= bus.dc_req_data;
          end else if (w_pickI) begin
            r_state       <= BUSY_I;
            r_icGrant     <= 1'b1;
            r_memReqValid <= 1'b1;
            r_memReqRw    <= 1'b0;
            r_memReqAddr  <= bus.ic_req_addr;
            r_memReqData  <= '0;
          end
        end
        // Completion always passes through IDLE, giving the one-cycle turnaround.
        BUSY_I: begin
          if (bus.mem_resp_valid) begin
            r_state       <= IDLE;
            r_icGrant     <= 1'b0;
            r_memReqValid <= 1'b0;
            r_lastSrv     <= SRV_I;
          end
        end
        BUSY_D: begin
          if (bus.mem_resp_valid) begin
            r_state       <= IDLE;
            r_dcGrant     <= 1'b0;
            r_memReqValid <= 1'b0;
            r_lastSrv     <= SRV_D;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_icGrant     <= 1'b0;
          r_dcGrant     <= 1'b0;
          r_memReqValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ic_grant      = r_icGrant;
  assign bus.dc_grant      = r_dcGrant;
  assign bus.mem_req_valid = r_memReqValid;
  assign bus.mem_req_rw    = r_memReqRw;
  assign bus.mem_req_addr  = r_memReqAddr;
  assign bus.mem_req_data  = r_memReqData;

  // Response data is forced to zero unless it belongs to the current owner.
  assign bus.ic_resp_valid = w_icResp;
  assign bus.ic_resp_data  = w_icResp ? bus.mem_resp_data : '0;
  assign bus.dc_resp_valid = w_dcResp;
  assign bus.dc_resp_data  = w_dcResp ? bus.mem_resp_data : '0;
endmodule
